bs_mac_serial: RTL and testbench
================================

# bs_mac_serial

Parametrised bit-serial signed multiply-accumulate unit for the binary-serial PE datapath. The unit consumes one bit of the multiplier per cycle and adds the shifted, sign-correct partial product of the multiplicand into a wide accumulator. It has its own bit counter, a run-time precision select, a valid/ready handshake on both sides, and an abort. One instance sits in each systolic PE in place of the bare partial-product selector plus external counter.

## Interface

Parameters:
- WIDTH, 8: operand width in bits; both operands are signed two's complement.
- ACC_WIDTH, 24: accumulator width; must be at least 2*WIDTH.
- CNT_W, $clog2(WIDTH+1): width of the precision field and the bit counter.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- i_valid, input, 1: operand pair offered.
- o_ready, output, 1: unit can accept operands; high only in IDLE.
- i_data0, input, WIDTH: multiplier, consumed serially LSB first.
- i_data1, input, WIDTH: multiplicand.
- i_prec, input, CNT_W: number of multiplier bits to process; 0 or any value above WIDTH means WIDTH.
- i_acc_clr, input, 1: sampled on accept; 1 means start from 0, 0 means add to the current o_acc.
- i_abort, input, 1: synchronous abort and clear.
- o_valid, output, 1: result available; high only in DONE.
- i_ready, input, 1: downstream accepts the result.
- o_acc, output, ACC_WIDTH signed: accumulator value.
- o_busy, output, 1: high in RUN.

## Operation

- States: IDLE, RUN, DONE. Reset state is IDLE. Reset values: o_acc=0, o_valid=0, o_busy=0, o_ready=1, counter=0.
- IDLE, on i_valid && o_ready:
  - latch data0, data1 and the effective precision P (clamped as above), idx=0;
  - if i_acc_clr, acc=0;
  - go to RUN.
- RUN, each cycle:
  - term = data0[idx] ? sext(data1) << idx : 0, computed at ACC_WIDTH;
  - if idx==P-1, acc -= term (sign bit carries negative weight); otherwise acc += term;
  - idx++;
  - after the cycle that processes idx==P-1, go to DONE.
- The multiplier is the P-bit signed value held in data0[P-1:0]; bits at P and above are ignored.
- DONE: o_valid=1 and o_acc is held stable. On i_ready, go to IDLE. i_valid is ignored while in DONE.
- Arithmetic wraps modulo 2^ACC_WIDTH. There is no saturation.
- i_abort, in any state, takes priority over every other input:
  - next state IDLE;
  - acc=0, idx=0, o_valid=0.
- Reset asserted mid-RUN: outputs go to their reset values immediately; no partial result survives.
- o_acc is visible in every state. During RUN it shows intermediate sums, and consumers must qualify it with o_valid.

## Timing

- Accept at edge t0. RUN occupies edges t1..tP, and o_valid rises after edge tP, i.e. P cycles after accept.
- The result handshake occurs at the first edge tR (at or after tP+1) where i_ready=1. The earliest next accept is edge tR+1.
- Minimum initiation interval is P+2 cycles.
- o_ready is combinational from state only. o_valid and o_busy are registered state decodes. There is no combinational path from any input to any output.
- Simultaneous i_abort and i_valid in IDLE: abort wins and nothing is accepted. Simultaneous i_abort and i_ready in DONE: abort wins and acc is cleared.

## Test plan

WIDTH=8, ACC_WIDTH=24 for all scenarios.

1. Basic multiply: accept data0=3, data1=5, prec=8, clr=1 -> o_valid exactly 8 cycles after accept, o_acc=15.
2. Signed operands: data0=0xFD (-3), data1=7, clr=1 -> o_acc=0xFFFFEB (-21).
   - Corner: data0=data1=0x80 -> o_acc=16384.
3. Accumulation: 10*10 with clr=1, then 2*(-4) with clr=0 -> first o_acc=100, second o_acc=92.
   - Back-to-back accepts occur at the minimum interval of 10 cycles.
4. Precision select:
   - prec=4, data0=0x0F, data1=6 -> o_acc=-6 (0xFFFFFA), o_valid 4 cycles after accept.
   - prec=0 with the same operands -> o_acc=90 after 8 cycles.
   - prec=12 -> treated as 8.
5. Backpressure: hold i_ready=0 for 5 cycles in DONE while toggling i_valid -> o_acc, o_valid=1 and o_ready=0 stay stable, and no new accept occurs; i_ready=1 -> IDLE on the next edge.
6. Abort and reset:
   - pulse i_abort at RUN cycle 3 -> IDLE next cycle, o_acc=0, o_valid never rises;
   - deassert rst_n mid-RUN -> all outputs at reset values asynchronously, and a fresh 3*5 afterwards gives 15.

Source files
------------

// File: rtl/bs_mac_serial.sv
// bs_mac_serial
// Bit-serial signed multiply-accumulate unit. The multiplier (data0) is
// consumed one bit per cycle, LSB first. Each set bit adds the sign-extended
// multiplicand (data1), shifted by the bit position, into a wide accumulator.
// The top processed bit carries negative weight, so that partial product is
// subtracted instead of added. The precision is selectable at run time, and
// there is a valid/ready handshake on both the operand and result sides.
//
// ACC_WIDTH must be at least 2*WIDTH so that a single product cannot wrap.

module bs_mac_serial #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [WIDTH-1:0]            i_data0,
  input  logic [WIDTH-1:0]            i_data1,
  input  logic [CNT_W-1:0]            i_prec,
  input  logic                        i_acc_clr,
  input  logic                        i_abort,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [ACC_WIDTH-1:0] o_acc,
  output logic                        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A requested precision of 0, or one above WIDTH, means full width.
  function automatic logic [CNT_W-1:0] eff_prec(input logic [CNT_W-1:0] p);
    logic [CNT_W-1:0] r;
    if ((p == {CNT_W{1'b0}}) || (p > CNT_W'(WIDTH))) begin
      r = CNT_W'(WIDTH);
    end else begin
      r = p;
    end
    return r;
  endfunction

  // Sign-extend the multiplicand to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] sext_mcand(input logic [WIDTH-1:0] d);
    return {{(ACC_WIDTH - WIDTH){d[WIDTH-1]}}, d};
  endfunction

  // Pick multiplier bit idx without a variable-width bit select.
  function automatic logic mplier_bit(input logic [WIDTH-1:0] d,
                                      input logic [CNT_W-1:0] idx);
    return |(d & (WIDTH'(1) << idx));
  endfunction

  state_t               state_r;
  logic [WIDTH-1:0]     data0_r;
  logic [WIDTH-1:0]     data1_r;
  logic [CNT_W-1:0]     prec_r;
  logic [CNT_W-1:0]     idx_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic                 valid_r;
  logic                 busy_r;

  logic                 bit_s;
  logic                 last_s;
  logic [ACC_WIDTH-1:0] term_s;
  logic [ACC_WIDTH-1:0] acc_next_s;

  // Partial product for the current bit and the resulting accumulator value.
  always_comb begin
    bit_s      = 1'b0;
    last_s     = 1'b0;
    term_s     = {ACC_WIDTH{1'b0}};
    acc_next_s = acc_r;
    bit_s  = mplier_bit(data0_r, idx_r);
    last_s = (idx_r == (prec_r - CNT_W'(1)));
    if (bit_s) begin
      term_s = sext_mcand(data1_r) << idx_r;
    end else begin
      term_s = {ACC_WIDTH{1'b0}};
    end
    if (last_s) begin
      acc_next_s = acc_r - term_s;
    end else begin
      acc_next_s = acc_r + term_s;
    end
  end

  // Control FSM with datapath registers; abort overrides everything but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      data0_r <= {WIDTH{1'b0}};
      data1_r <= {WIDTH{1'b0}};
      prec_r  <= CNT_W'(WIDTH);
      idx_r   <= {CNT_W{1'b0}};
      acc_r   <= {ACC_WIDTH{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else if (i_abort) begin
      state_r <= ST_IDLE;
      idx_r   <= {CNT_W{1'b0}};
      acc_r   <= {ACC_WIDTH{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_valid) begin
            data0_r <= i_data0;
            data1_r <= i_data1;
            prec_r  <= eff_prec(i_prec);
            idx_r   <= {CNT_W{1'b0}};
            if (i_acc_clr) begin
              acc_r <= {ACC_WIDTH{1'b0}};
            end else begin
              acc_r <= acc_r;
            end
            state_r <= ST_RUN;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + CNT_W'(1);
          if (last_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            valid_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          idx_r   <= {CNT_W{1'b0}};
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = (state_r == ST_IDLE);
  assign o_valid = valid_r;
  assign o_busy  = busy_r;
  assign o_acc   = acc_r;

endmodule

// File: tb/tb_bs_mac_serial.sv
// Directed self-checking bench for bs_mac_serial (WIDTH=8, ACC_WIDTH=24).
// Inputs change 1ns after the rising edge and outputs are sampled there too.

module tb_bs_mac_serial;

  logic               clk;
  logic               rst_n;
  logic               i_valid;
  logic               o_ready;
  logic [7:0]         i_data0;
  logic [7:0]         i_data1;
  logic [3:0]         i_prec;
  logic               i_acc_clr;
  logic               i_abort;
  logic               o_valid;
  logic               i_ready;
  logic signed [23:0] o_acc;
  logic               o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  bs_mac_serial #(.WIDTH(8), .ACC_WIDTH(24)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data0  (i_data0),
    .i_data1  (i_data1),
    .i_prec   (i_prec),
    .i_acc_clr(i_acc_clr),
    .i_abort  (i_abort),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_acc    (o_acc),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair, wait for the result; lat = cycles from accept to o_valid.
  task automatic do_op(input logic [7:0] d0, input logic [7:0] d1, input logic [3:0] p,
                       input logic clr, output logic [23:0] acc, output int lat);
    int guard;
    guard = 0;
    while (!o_ready && guard < 50) begin
      tick();
      guard++;
    end
    i_data0 = d0; i_data1 = d1; i_prec = p; i_acc_clr = clr; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      tick();
      lat++;
    end
    acc = o_acc;
  endtask

  task automatic release_result();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({o_acc, o_valid, o_busy, o_ready} !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_values acc=%h valid=%b busy=%b ready=%b want 000000 0 0 1",
               o_acc, o_valid, o_busy, o_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [23:0] acc;
    int lat;
    do_op(8'd3, 8'd5, 4'd8, 1'b1, acc, lat);
    n_tests++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency got=%0d want=8", lat); end
    n_tests++;
    if (acc !== 24'd15) begin n_fail++; $display("FAIL basic_acc got=%h want=00000f", acc); end
    release_result();
  endtask

  task automatic test_signed();
    logic [23:0] acc;
    int lat;
    do_op(8'hFD, 8'd7, 4'd8, 1'b1, acc, lat);
    n_tests++;
    if (acc !== 24'hFFFFEB) begin n_fail++; $display("FAIL signed_neg3x7 got=%h want=ffffeb", acc); end
    release_result();
    do_op(8'h80, 8'h80, 4'd8, 1'b1, acc, lat);
    n_tests++;
    if (acc !== 24'd16384) begin n_fail++; $display("FAIL signed_min_sq got=%h want=004000", acc); end
    release_result();
  endtask

  // 10*10 then +2*(-4) accepted at the minimum initiation interval of 10 cycles.
  task automatic test_back_to_back();
    int cnt;
    i_ready = 1'b1;
    i_data0 = 8'd10; i_data1 = 8'd10; i_prec = 4'd8; i_acc_clr = 1'b1; i_valid = 1'b1;
    tick();
    i_data0 = 8'd2; i_data1 = 8'hFC; i_acc_clr = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    n_tests++;
    if ({o_valid, o_acc} !== {1'b1, 24'd100}) begin
      n_fail++; $display("FAIL b2b_first valid=%b acc=%h want 1 000064", o_valid, o_acc);
    end
    tick();
    n_tests++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_at_9 got=%b want=1", o_ready); end
    tick();
    i_valid = 1'b0;
    n_tests++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_at_10 busy=%b want=1", o_busy); end
    cnt = 0;
    while (!o_valid && cnt < 40) begin tick(); cnt++; end
    n_tests++;
    if (cnt !== 8 || o_acc !== 24'd92) begin
      n_fail++; $display("FAIL b2b_second lat=%0d acc=%h want 8 00005c", cnt, o_acc);
    end
    tick();
    i_ready = 1'b0;
  endtask

  task automatic test_precision();
    logic [23:0] acc;
    int lat;
    do_op(8'h0F, 8'd6, 4'd4, 1'b1, acc, lat);
    n_tests++;
    if (lat !== 4 || acc !== 24'hFFFFFA) begin
      n_fail++; $display("FAIL prec4 lat=%0d acc=%h want 4 fffffa", lat, acc);
    end
    release_result();
    do_op(8'hAF, 8'd6, 4'd4, 1'b1, acc, lat);
    n_tests++;
    if (acc !== 24'hFFFFFA) begin n_fail++; $display("FAIL prec4_high_ignored got=%h want=fffffa", acc); end
    release_result();
    do_op(8'h0F, 8'd6, 4'd0, 1'b1, acc, lat);
    n_tests++;
    if (lat !== 8 || acc !== 24'd90) begin
      n_fail++; $display("FAIL prec0 lat=%0d acc=%h want 8 00005a", lat, acc);
    end
    release_result();
    do_op(8'h0F, 8'd6, 4'd12, 1'b1, acc, lat);
    n_tests++;
    if (lat !== 8 || acc !== 24'd90) begin
      n_fail++; $display("FAIL prec12 lat=%0d acc=%h want 8 00005a", lat, acc);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    logic [23:0] acc;
    int lat;
    do_op(8'd9, 8'd11, 4'd8, 1'b1, acc, lat);
    for (int k = 0; k < 5; k++) begin
      i_valid = k[0] ? 1'b0 : 1'b1;
      i_data0 = 8'd1; i_data1 = 8'd1; i_acc_clr = 1'b1;
      tick();
      n_tests++;
      if ({o_valid, o_ready, o_busy, o_acc} !== {1'b1, 1'b0, 1'b0, 24'd99}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d valid=%b ready=%b busy=%b acc=%h want 1 0 0 000063",
                 k, o_valid, o_ready, o_busy, o_acc);
      end
    end
    i_valid = 1'b0;
    release_result();
    n_tests++;
    if ({o_valid, o_ready, o_acc} !== {1'b0, 1'b1, 24'd99}) begin
      n_fail++; $display("FAIL bp_release valid=%b ready=%b acc=%h want 0 1 000063", o_valid, o_ready, o_acc);
    end
  endtask

  task automatic test_abort();
    logic seen_valid;
    i_data0 = 8'hFF; i_data1 = 8'd5; i_prec = 4'd8; i_acc_clr = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick(); tick(); tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    n_tests++;
    if ({o_ready, o_busy, o_valid, o_acc} !== {1'b1, 1'b0, 1'b0, 24'h0}) begin
      n_fail++; $display("FAIL abort_run ready=%b busy=%b valid=%b acc=%h want 1 0 0 000000",
                         o_ready, o_busy, o_valid, o_acc);
    end
    seen_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (o_valid) seen_valid = 1'b1;
    end
    n_tests++;
    if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid got=%b want=0", seen_valid); end
    i_abort = 1'b1; i_valid = 1'b1;
    tick();
    i_abort = 1'b0; i_valid = 1'b0;
    n_tests++;
    if ({o_ready, o_busy} !== 2'b10) begin
      n_fail++; $display("FAIL abort_vs_valid ready=%b busy=%b want 1 0", o_ready, o_busy);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [23:0] acc;
    int lat;
    i_data0 = 8'hFF; i_data1 = 8'h7F; i_prec = 4'd8; i_acc_clr = 1'b1; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_acc, o_valid, o_busy, o_ready} !== {24'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid_run acc=%h valid=%b busy=%b ready=%b want 000000 0 0 1",
                         o_acc, o_valid, o_busy, o_ready);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_op(8'd3, 8'd5, 4'd8, 1'b0, acc, lat);
    n_tests++;
    if (lat !== 8 || acc !== 24'd15) begin
      n_fail++; $display("FAIL after_reset lat=%0d acc=%h want 8 00000f", lat, acc);
    end
    release_result();
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data0 = 8'h0; i_data1 = 8'h0; i_prec = 4'h0;
    i_acc_clr = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_precision();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
